// File: rtl/reg_file_sb.sv
// ============================================================================
//  Module      : reg_file_sb
//  Description : Architectural register file with a per-register busy
//                scoreboard. NUM_RD combinational read ports with write
//                bypass, one writeback port (clears busy), one reserve port
//                (sets busy) and a registered count of busy registers.
//                Register 0 is hardwired to zero and never busy.
//  Ports       : clk        - clock, all state updates on rising edge
//                rst_n      - synchronous active-low reset
//                rd_addr    - packed read addresses, port i at [i*AW +: AW]
//                rd_data    - packed read data, port i at [i*XLEN +: XLEN]
//                rd_busy    - per-port flag: addressed register is pending
//                wr_en      - writeback strobe
//                wr_addr    - writeback register index
//                wr_data    - writeback value
//                rsv_en     - reserve strobe
//                rsv_addr   - reserve register index
//                busy_count - number of registers currently busy
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_sb #(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32,
    parameter int NUM_RD   = 2,
    localparam int AW      = $clog2(NUM_REGS),
    localparam int CW      = $clog2(NUM_REGS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic                   rsv_en,
    input  logic [AW-1:0]          rsv_addr,
    output logic [CW-1:0]          busy_count
);

    // One extra bit so NUM_REGS itself is representable for range checks
    // (NUM_REGS may be a power of two, e.g. 32 with AW=5).
    localparam int            c_aw1      = AW + 1;
    localparam logic [AW:0]   c_num_regs = c_aw1'(NUM_REGS);

    logic [XLEN-1:0]     r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [CW-1:0]       r_busy_count;

    logic                w_wr_ok;
    logic                w_rsv_ok;
    logic [NUM_REGS-1:0] w_busy_next;
    logic                w_inc;
    logic                w_dec;
    logic [CW-1:0]       w_count_next;

    // Register 0 and out-of-range indices are silently dropped.
    assign w_wr_ok  = wr_en  && (wr_addr  != '0) && ({1'b0, wr_addr}  < c_num_regs);
    assign w_rsv_ok = rsv_en && (rsv_addr != '0) && ({1'b0, rsv_addr} < c_num_regs);

    // Write clears, then reserve sets: a same-register collision leaves the
    // bit set because the reserve refers to a newer in-flight producer.
    always_comb begin
        w_busy_next = r_busy;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_wr_ok && (wr_addr == AW'(i))) begin
                w_busy_next[i] = 1'b0;
            end
            if (w_rsv_ok && (rsv_addr == AW'(i))) begin
                w_busy_next[i] = 1'b1;
            end
        end
    end

    // Count only net bit transitions. A write to a register that is being
    // reserved in the same cycle never clears it, so it cannot decrement.
    always_comb begin
        w_inc = w_rsv_ok && !r_busy[rsv_addr];
        w_dec = w_wr_ok && r_busy[wr_addr] && !(w_rsv_ok && (rsv_addr == wr_addr));
        w_count_next = r_busy_count;
        if (w_inc && !w_dec) begin
            w_count_next = r_busy_count + CW'(1);
        end else if (w_dec && !w_inc) begin
            w_count_next = r_busy_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[wr_addr] <= wr_data;
            end
            r_busy       <= w_busy_next;
            r_busy_count <= w_count_next;
        end
    end

    assign busy_count = r_busy_count;

    // Read ports: zero-latency, with bypass of the write arriving this cycle.
    // Reserves are deliberately not bypassed.
    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            logic [AW-1:0] w_addr;
            logic          w_valid;

            assign w_addr  = rd_addr[p*AW +: AW];
            assign w_valid = (w_addr != '0) && ({1'b0, w_addr} < c_num_regs);

            always_comb begin
                rd_data[p*XLEN +: XLEN] = '0;
                rd_busy[p]              = 1'b0;
                if (w_valid) begin
                    if (w_wr_ok && (wr_addr == w_addr)) begin
                        rd_data[p*XLEN +: XLEN] = wr_data;
                    end else begin
                        rd_data[p*XLEN +: XLEN] = r_regs[w_addr];
                        rd_busy[p]              = r_busy[w_addr];
                    end
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// ============================================================================
//  Module      : tb_reg_file_sb
//  Description : Self-checking bench for reg_file_sb. Instance "dut" uses the
//                default 32-register configuration and is checked against an
//                array-based reference model; instance "dut24" uses 24
//                registers to exercise out-of-range addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_sb;

    localparam int N = 32;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (32 registers)
    logic        rst_n    = 1'b0;
    logic        wr_en    = 1'b0;
    logic [4:0]  wr_addr  = '0;
    logic [31:0] wr_data  = '0;
    logic        rsv_en   = 1'b0;
    logic [4:0]  rsv_addr = '0;
    logic [9:0]  rd_addr  = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [5:0]  busy_count;

    // Secondary instance (24 registers)
    logic        b_rst_n    = 1'b0;
    logic        b_wr_en    = 1'b0;
    logic [4:0]  b_wr_addr  = '0;
    logic [31:0] b_wr_data  = '0;
    logic        b_rsv_en   = 1'b0;
    logic [4:0]  b_rsv_addr = '0;
    logic [9:0]  b_rd_addr  = '0;
    logic [63:0] b_rd_data;
    logic [1:0]  b_rd_busy;
    logic [4:0]  b_busy_count;

    reg_file_sb #(.NUM_REGS(32), .XLEN(32), .NUM_RD(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .busy_count (busy_count)
    );

    reg_file_sb #(.NUM_REGS(24), .XLEN(32), .NUM_RD(2)) dut24 (
        .clk        (clk),
        .rst_n      (b_rst_n),
        .rd_addr    (b_rd_addr),
        .rd_data    (b_rd_data),
        .rd_busy    (b_rd_busy),
        .wr_en      (b_wr_en),
        .wr_addr    (b_wr_addr),
        .wr_data    (b_wr_data),
        .rsv_en     (b_rsv_en),
        .rsv_addr   (b_rsv_addr),
        .busy_count (b_busy_count)
    );

    // Reference model: plain architectural state
    logic [31:0] m_regs [N];
    bit          m_busy [N];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int popcount();
        int c = 0;
        for (int i = 0; i < N; i++) begin
            if (m_busy[i]) c++;
        end
        return c;
    endfunction

    function automatic bit writes_here(int a);
        return wr_en && (int'(wr_addr) == a);
    endfunction

    function automatic logic [31:0] exp_data(int a);
        if (a == 0 || a >= N) return 32'h0;
        if (writes_here(a)) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(int a);
        if (a == 0 || a >= N) return 1'b0;
        if (writes_here(a)) return 1'b0;
        return m_busy[a];
    endfunction

    // Apply inputs at the falling edge, then check outputs against the model.
    task automatic drive(input logic rn, input logic we, input int wa, input logic [31:0] wd,
                         input logic re, input int ra, input int a0, input int a1);
        int addrs [2];
        @(negedge clk);
        rst_n    = rn;
        wr_en    = we;
        wr_addr  = wa[4:0];
        wr_data  = wd;
        rsv_en   = re;
        rsv_addr = ra[4:0];
        rd_addr  = {a1[4:0], a0[4:0]};
        addrs[0] = a0;
        addrs[1] = a1;
        #1;
        check("busy_count", 64'(busy_count), 64'(popcount()));
        if (rn) begin
            for (int p = 0; p < 2; p++) begin
                check($sformatf("rd_data[%0d] a=%0d", p, addrs[p]),
                      64'(rd_data[p*32 +: 32]), 64'(exp_data(addrs[p])));
                check($sformatf("rd_busy[%0d] a=%0d", p, addrs[p]),
                      64'(rd_busy[p]), 64'(exp_busy(addrs[p])));
            end
        end
    endtask

    // Advance the model across the rising edge using the applied inputs.
    task automatic commit();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) begin
                m_busy[rsv_addr] = 1'b1;
            end
        end
    endtask

    task automatic idle(input int a0, input int a1);
        drive(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, a0, a1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end

        // Reset
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 0, 0); commit();
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 0, 0); commit();
        idle(5, 17);
        check("post_reset_data", rd_data, 64'h0);
        check("post_reset_busy", 64'(rd_busy), 64'h0);
        check("post_reset_count", 64'(busy_count), 64'h0);
        commit();

        // Write x5, read it on both ports
        drive(1'b1, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 0, 0); commit();
        idle(5, 5);
        check("x5_p0", 64'(rd_data[31:0]), 64'hDEADBEEF);
        check("x5_p1", 64'(rd_data[63:32]), 64'hDEADBEEF);
        check("x5_busy", 64'(rd_busy), 64'h0);
        commit();

        // x0 is hardwired
        drive(1'b1, 1'b1, 0, 32'h1234, 1'b1, 0, 0, 0);
        check("x0_bypass", rd_data, 64'h0);
        commit();
        idle(0, 0);
        check("x0_data", rd_data, 64'h0);
        check("x0_busy", 64'(rd_busy), 64'h0);
        check("x0_count", 64'(busy_count), 64'h0);
        commit();

        // Reserve x7, then write with same-cycle bypass
        drive(1'b1, 1'b0, 0, 32'h0, 1'b1, 7, 7, 7);
        check("rsv_no_bypass", 64'(rd_busy), 64'h0);
        commit();
        idle(7, 7);
        check("x7_busy", 64'(rd_busy), 64'h3);
        check("x7_count1", 64'(busy_count), 64'h1);
        commit();
        drive(1'b1, 1'b1, 7, 32'hA5, 1'b0, 0, 7, 0);
        check("x7_bypass_data", 64'(rd_data[31:0]), 64'hA5);
        check("x7_bypass_busy", 64'(rd_busy[0]), 64'h0);
        commit();
        idle(7, 0);
        check("x7_count0", 64'(busy_count), 64'h0);
        commit();

        // x9 busy, then write+reserve collision: reserve wins
        drive(1'b1, 1'b0, 0, 32'h0, 1'b1, 9, 0, 0); commit();
        idle(9, 0); commit();
        drive(1'b1, 1'b1, 9, 32'h55, 1'b1, 9, 9, 0); commit();
        idle(9, 9);
        check("x9_data", 64'(rd_data[31:0]), 64'h55);
        check("x9_busy", 64'(rd_busy), 64'h3);
        check("x9_count", 64'(busy_count), 64'h1);
        commit();

        // Fill the scoreboard, then reset with a concurrent write
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 1'b0, 0, 32'h0, 1'b1, i, i, 0); commit();
        end
        idle(31, 1);
        check("full_count", 64'(busy_count), 64'd31);
        commit();
        drive(1'b0, 1'b1, 3, 32'hFFFF, 1'b1, 4, 3, 4); commit();
        idle(3, 5);
        check("rst_wr_data", rd_data, 64'h0);
        check("rst_wr_busy", 64'(rd_busy), 64'h0);
        check("rst_wr_count", 64'(busy_count), 64'h0);
        commit();

        // 24-register instance: address 30 is out of range
        @(negedge clk);
        b_rst_n = 1'b1;
        b_wr_en = 1'b1; b_wr_addr = 5'd3;  b_wr_data = 32'h77;
        b_rsv_en = 1'b1; b_rsv_addr = 5'd23;
        @(negedge clk);
        b_wr_en = 1'b1; b_wr_addr = 5'd30; b_wr_data = 32'hBAD;
        b_rsv_en = 1'b1; b_rsv_addr = 5'd30;
        b_rd_addr = {5'd3, 5'd30};
        #1;
        check("n24_a30_bypass", 64'(b_rd_data[31:0]), 64'h0);
        check("n24_a30_busy0", 64'(b_rd_busy[0]), 64'h0);
        check("n24_x3", 64'(b_rd_data[63:32]), 64'h77);
        check("n24_count1", 64'(b_busy_count), 64'h1);
        @(negedge clk);
        b_wr_en = 1'b0; b_rsv_en = 1'b0;
        b_rd_addr = {5'd23, 5'd30};
        #1;
        check("n24_a30_data", 64'(b_rd_data[31:0]), 64'h0);
        check("n24_a30_busy", 64'(b_rd_busy[0]), 64'h0);
        check("n24_x23_busy", 64'(b_rd_busy[1]), 64'h1);
        check("n24_count_after", 64'(b_busy_count), 64'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic        rn, we, re;
            int          wa, ra, a0, a1;
            logic [31:0] wd;
            rn = ($urandom_range(0, 99) != 0);
            we = ($urandom_range(0, 1) == 1);
            re = ($urandom_range(0, 9) < 4);
            wa = int'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 31));
            a0 = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 2) == 0) ? ra : int'($urandom_range(0, 31));
            wd = $urandom;
            drive(rn, we, wa, wd, re, ra, a0, a1);
            commit();
        end
        idle(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
